// File: rtl/sopc_be_gpio_pkg.sv
// Shared constants and helpers for the debounced GPIO input port with IRQ.
package sopc_be_gpio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_MODE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_ANY  = 2'b10
  } edge_mode_e;

  // Per-bit edge hits for a given edge_mode; both 10 and 11 select any edge.
  function automatic logic [BUS_W-1:0] edge_detect(input logic [1:0]       mode,
                                                   input logic [BUS_W-1:0] cur,
                                                   input logic [BUS_W-1:0] prev);
    logic [BUS_W-1:0] rise;
    logic [BUS_W-1:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    if (mode[1])                  edge_detect = rise | fall;
    else if (mode == 2'(EDGE_FALL)) edge_detect = fall;
    else                          edge_detect = rise;
  endfunction

endpackage

// File: rtl/sopc_be_gpio_debounce.sv
// One input channel: metastability synchroniser followed by an optional debounce filter.
module sopc_be_gpio_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign level = sync_in;
    end else begin : g_filter
      localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt;
      logic             level_q;

      // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt     <= '0;
          level_q <= 1'b0;
        end else if (sync_in != level_q) begin
          if (cnt == CNT_LAST) begin
            level_q <= sync_in;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end

      assign level = level_q;
    end
  endgenerate

endmodule

// File: rtl/sopc_be_gpio_in_irq.sv
// Avalon-MM GPIO input port: synchronised/debounced inputs, edge capture, masked level IRQ.
module sopc_be_gpio_in_irq
  import sopc_be_gpio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_MASK      = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [1:0]       edge_mode;

  logic             wr_en_c;
  logic [WIDTH-1:0] edge_hit_c;
  logic [WIDTH-1:0] clr_c;
  logic [31:0]      rd_mux_c;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  // One synchroniser/debounce channel per input pin.
  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
      sopc_be_gpio_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_port[i]),
        .level   (level[i])
      );
    end
  endgenerate

  assign wr_en_c    = chipselect & ~write_n;
  assign edge_hit_c = WIDTH'(edge_detect(edge_mode, BUS_W'(level), BUS_W'(level_d)));
  assign clr_c      = (wr_en_c && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // Read mux of the current address, using register state before any same-cycle write.
  always_comb begin
    rd_mux_c = '0;
    case (address)
      ADDR_DATA: rd_mux_c = BUS_W'(level);
      ADDR_MASK: rd_mux_c = BUS_W'(irq_mask);
      ADDR_EDGE: rd_mux_c = BUS_W'(edge_capture);
      ADDR_MODE: rd_mux_c = BUS_W'(edge_mode);
      default:   rd_mux_c = '0;
    endcase
  end

  // Register file, edge capture (set beats clear) and registered IRQ.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata     <= '0;
      irq          <= 1'b0;
      level_d      <= '0;
      edge_capture <= '0;
      edge_mode    <= 2'(EDGE_RISE);
      irq_mask     <= RESET_MASK;
    end else begin
      readdata     <= rd_mux_c;
      irq          <= |(edge_capture & irq_mask);
      level_d      <= level;
      edge_capture <= (edge_capture & ~clr_c) | edge_hit_c;
      if (wr_en_c && (address == ADDR_MASK)) irq_mask  <= writedata[WIDTH-1:0];
      if (wr_en_c && (address == ADDR_MODE)) edge_mode <= writedata[1:0];
    end
  end

endmodule

// File: tb/tb_sopc_be_gpio_in_irq.sv
// Bench for sopc_be_gpio_in_irq: one undebounced and one 4-cycle debounced instance on shared inputs.
module tb_sopc_be_gpio_in_irq;

  localparam int S   = 2;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata0, readdata1;
  logic        irq0, irq1;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  sopc_be_gpio_in_irq #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0), .RESET_MASK(8'h00)) u_fast (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata0), .in_port(in_port), .irq(irq0));

  sopc_be_gpio_in_irq #(.WIDTH(8), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .RESET_MASK(8'h00)) u_deb (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata1), .in_port(in_port), .irq(irq1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = no debounce, index 1 = DEB-sample debounce.
  logic [7:0]  m_syn  [2][S];
  logic [7:0]  m_hist [2][DEB];
  logic [7:0]  m_lvl [2], m_lvl_d [2], m_cap [2], m_mask [2];
  logic [1:0]  m_mode [2];
  logic [31:0] m_rd [2];
  logic        m_irq [2];

  always @(posedge clk) begin : model
    logic [7:0] sin, cur, ed, clr;
    logic       acc, wr;
    wr = chipselect && !write_n;
    for (int k = 0; k < 2; k++) begin
      sin = m_syn[k][S-1];
      cur = (k == 0) ? sin : m_lvl[k];
      case (m_mode[k])
        2'd0:    ed = cur & ~m_lvl_d[k];
        2'd1:    ed = ~cur & m_lvl_d[k];
        default: ed = cur ^ m_lvl_d[k];
      endcase
      if (!reset_n) begin
        m_rd[k] = 0; m_irq[k] = 0; m_lvl[k] = 0; m_lvl_d[k] = 0;
        m_cap[k] = 0; m_mask[k] = 0; m_mode[k] = 0;
        for (int j = 0; j < DEB; j++) m_hist[k][j] = 0;
        for (int s = 0; s < S; s++) m_syn[k][s] = 0;
      end else begin
        case (address)
          2'd0: m_rd[k] = {24'h0, cur};
          2'd1: m_rd[k] = {24'h0, m_mask[k]};
          2'd2: m_rd[k] = {24'h0, m_cap[k]};
          default: m_rd[k] = {30'h0, m_mode[k]};
        endcase
        m_irq[k] = |(m_cap[k] & m_mask[k]);
        clr = (wr && address == 2'd2) ? writedata[7:0] : 8'h00;
        m_cap[k] = (m_cap[k] & ~clr) | ed;
        if (wr && address == 2'd1) m_mask[k] = writedata[7:0];
        if (wr && address == 2'd3) m_mode[k] = writedata[1:0];
        m_lvl_d[k] = cur;
        if (k == 1) begin
          // A bit flips once the last DEB synchronised samples all disagree with it.
          for (int i = 0; i < 8; i++) begin
            acc = (sin[i] != m_lvl[k][i]);
            for (int j = 0; j < DEB-1; j++) acc = acc && (m_hist[k][j][i] != m_lvl[k][i]);
            if (acc) m_lvl[k][i] = ~m_lvl[k][i];
          end
          for (int j = DEB-1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
          m_hist[k][0] = sin;
        end
        for (int s = S-1; s > 0; s--) m_syn[k][s] = m_syn[k][s-1];
        m_syn[k][0] = in_port;
      end
    end
  end

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd_fast", readdata0, m_rd[0]);
      check("model_irq_fast", {31'h0, irq0}, {31'h0, m_irq[0]});
      check("model_rd_deb", readdata1, m_rd[1]);
      check("model_irq_deb", {31'h0, irq1}, {31'h0, m_irq[1]});
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] q0, output logic [31:0] q1);
    @(negedge clk); address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk); q0 = readdata0; q1 = readdata1; chipselect = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] q0, q1;
    tbl[0]  = '{2'd0, 1'b0, 32'h0};
    tbl[1]  = '{2'd1, 1'b0, 32'h0};
    tbl[2]  = '{2'd2, 1'b0, 32'h0};
    tbl[3]  = '{2'd3, 1'b0, 32'h0};
    tbl[4]  = '{2'd1, 1'b1, 32'hFFFF_FF3C};
    tbl[5]  = '{2'd1, 1'b0, 32'h0000_003C};
    tbl[6]  = '{2'd3, 1'b1, 32'hFFFF_FFFE};
    tbl[7]  = '{2'd3, 1'b0, 32'h0000_0002};
    tbl[8]  = '{2'd0, 1'b1, 32'hFFFF_FFFF};
    tbl[9]  = '{2'd0, 1'b0, 32'h0};
    tbl[10] = '{2'd2, 1'b1, 32'h0000_00FF};
    tbl[11] = '{2'd2, 1'b0, 32'h0};
    tbl[12] = '{2'd1, 1'b1, 32'h0};
    tbl[13] = '{2'd1, 1'b0, 32'h0};
    tbl[14] = '{2'd3, 1'b1, 32'h0};
    tbl[15] = '{2'd3, 1'b0, 32'h0};

    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 8'h00;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_rd_fast", readdata0, 32'h0);
    check("reset_irq_fast", {31'h0, irq0}, 32'h0);
    check("reset_irq_deb", {31'h0, irq1}, 32'h0);
    reset_n = 1'b1;

    // Register access table with idle inputs.
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
      else begin
        bus_read(tbl[i].addr, q0, q1);
        check($sformatf("tbl%0d_fast", i), q0, tbl[i].data);
        check($sformatf("tbl%0d_deb", i), q1, tbl[i].data);
      end
    end

    // Input latency through the synchroniser, with and without debounce.
    @(negedge clk); address = 2'd0; in_port = 8'hA5;
    wait_n(1);
    check("data_fast_early", readdata0, 32'h0);
    wait_n(3);
    check("data_fast_a5", readdata0, 32'h0000_00A5);
    check("data_deb_pending", readdata1, 32'h0);
    wait_n(4);
    check("data_deb_a5", readdata1, 32'h0000_00A5);
    in_port = 8'h00;
    wait_n(10);
    bus_write(2'd2, 32'hFF);

    // Short glitch rejected, long pulse accepted by the debounced channel.
    @(negedge clk); in_port = 8'h01;
    wait_n(3); in_port = 8'h00;
    wait_n(10);
    bus_read(2'd0, q0, q1); check("glitch_data_deb", q1, 32'h0);
    bus_read(2'd2, q0, q1); check("glitch_cap_deb", q1, 32'h0);
    @(negedge clk); in_port = 8'h01;
    wait_n(7);
    bus_read(2'd0, q0, q1); check("pulse_data_hi_deb", q1, 32'h1);
    @(negedge clk); in_port = 8'h00;
    wait_n(10);
    bus_read(2'd0, q0, q1); check("pulse_data_lo_deb", q1, 32'h0);
    bus_read(2'd2, q0, q1); check("pulse_cap_deb", q1, 32'h1);
    bus_write(2'd2, 32'hFF);

    // Mask and interrupt on the undebounced instance, rising mode.
    bus_write(2'd1, 32'h01);
    @(negedge clk); in_port = 8'h01;
    wait_n(5);
    check("irq_set_fast", {31'h0, irq0}, 32'h1);
    bus_write(2'd2, 32'h1);
    wait_n(1);
    check("irq_clr_fast", {31'h0, irq0}, 32'h0);
    bus_read(2'd2, q0, q1); check("cap_clr_fast", q0, 32'h0);
    @(negedge clk); in_port = 8'h03;
    wait_n(5);
    check("irq_masked_fast", {31'h0, irq0}, 32'h0);
    bus_read(2'd2, q0, q1); check("cap_masked_fast", q0, 32'h2);

    // Falling-only then any-edge mode on bit 3.
    bus_write(2'd2, 32'hFF); bus_write(2'd3, 32'h1);
    @(negedge clk); in_port = 8'h0B; wait_n(5);
    bus_read(2'd2, q0, q1); check("fall_mode_rise", q0, 32'h0);
    @(negedge clk); in_port = 8'h03; wait_n(5);
    bus_read(2'd2, q0, q1); check("fall_mode_fall", q0, 32'h8);
    bus_write(2'd2, 32'hFF); bus_write(2'd3, 32'h2);
    @(negedge clk); in_port = 8'h0B; wait_n(5);
    bus_read(2'd2, q0, q1); check("any_mode_rise", q0, 32'h8);
    bus_write(2'd2, 32'hFF);
    @(negedge clk); in_port = 8'h03; wait_n(5);
    bus_read(2'd2, q0, q1); check("any_mode_fall", q0, 32'h8);
    bus_write(2'd3, 32'h0);
    bus_read(2'd2, q0, q1); check("mode_change_keeps_cap", q0, 32'h8);

    // Same-cycle clear and new edge on bit 2: the set wins.
    bus_write(2'd3, 32'h2); bus_write(2'd2, 32'hFF);
    @(negedge clk); in_port = 8'h07; wait_n(5);
    bus_read(2'd2, q0, q1); check("bit2_rise_fast", q0, 32'h4);
    @(negedge clk); in_port = 8'h03;
    wait_n(2);
    address = 2'd2; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h4;
    @(negedge clk); chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    bus_read(2'd2, q0, q1); check("set_beats_clr_fast", q0, 32'h4);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, q0, q1); check("plain_clr_fast", q0, 32'h0);

    // Reset in the middle of a debounce count.
    @(negedge clk); in_port = 8'hF0;
    wait_n(3);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_rd_deb", readdata1, 32'h0);
    check("midrst_irq_fast", {31'h0, irq0}, 32'h0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), q0, q1);
      check($sformatf("post_rst_deb_a%0d", a), q1, 32'h0);
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ (8'($urandom) & 8'($urandom));
      address    = 2'($urandom);
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      reset_n    = ($urandom_range(0, 399) != 0);
    end
    @(negedge clk); reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    wait_n(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
